// File: rtl/score_pkg.sv
// Shared geometry, FSM state and BCD types for the score display.
package score_pkg;

  localparam int unsigned GLYPH_W     = 24;
  localparam int unsigned GLYPH_H     = 24;
  localparam int unsigned GLYPH_DEPTH = GLYPH_W * GLYPH_H;

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  typedef logic [3:0] bcd_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift/add-3 step per cycle, saturating to all nines.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [SCORE_W-1:0]          bin,
  output logic                        busy,
  output logic                        done,
  output bcd_t [NUM_DIGITS-1:0]       bcd
);

  localparam int unsigned BcdW   = 4 * NUM_DIGITS;
  localparam int unsigned MaxVal = pow10(NUM_DIGITS) - 1;
  localparam int unsigned CntW   = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] sh_q, sat;
  logic [BcdW-1:0]    acc_q, adj;
  logic [CntW-1:0]    cnt_q;

  always_comb begin
    sat = bin;
    if (32'(bin) > MaxVal) sat = SCORE_W'(MaxVal);
  end

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sh_q  <= sat;
      acc_q <= '0;
      cnt_q <= CntW'(SCORE_W);
    end else if (busy) begin
      sh_q  <= sh_q << 1;
      acc_q <= {adj[BcdW-2:0], sh_q[SCORE_W-1]};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy = (cnt_q != '0);
  // High during the final iteration, so the result is stable the next cycle.
  assign done = (cnt_q == CntW'(1));
  assign bcd  = acc_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Score-to-glyph raster controller: BCD conversion with atomic commit plus a 3-stage pixel path.
// Define SCORE_LEADING_ZERO_BLANK_EN to suppress leading zero slots.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned ORIGIN_X   = 16,
  parameter int unsigned ORIGIN_Y   = 8,
  parameter int unsigned GLYPH_W    = score_pkg::GLYPH_W,
  parameter int unsigned GLYPH_H    = score_pkg::GLYPH_H,
  parameter int unsigned DIGIT_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_load,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               rom_q,
  output logic [3:0]         rom_digit,
  output logic [9:0]         rom_addr,
  output logic               pixel_on,
  output logic               busy
);

  localparam int unsigned Pitch = GLYPH_W + DIGIT_GAP;
  localparam int unsigned BoxW  = NUM_DIGITS * Pitch - DIGIT_GAP;

  state_e                state_q;
  logic                  pend_valid_q;
  logic [SCORE_W-1:0]    pend_val_q, start_val;
  logic                  start, conv_busy, conv_done;
  bcd_t [NUM_DIGITS-1:0] disp_q, conv_bcd;

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCORE_W   (SCORE_W)
  ) u_bin2bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (start_val),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // A load seen in COMMIT is newer than any pending value, so it wins.
  always_comb begin
    start     = 1'b0;
    start_val = score;
    case (state_q)
      StIdle:   start = score_load;
      StCommit: begin
        start = score_load | pend_valid_q;
        if (!score_load) start_val = pend_val_q;
      end
      default:  start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      disp_q       <= '0;
    end else begin
      case (state_q)
        StIdle: if (score_load) state_q <= StConvert;
        StConvert: begin
          if (score_load) begin
            pend_valid_q <= 1'b1;
            pend_val_q   <= score;
          end
          if (conv_done || !conv_busy) state_q <= StCommit;
        end
        StCommit: begin
          disp_q       <= conv_bcd;
          pend_valid_q <= 1'b0;
          state_q      <= start ? StConvert : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  // Per-slot draw enable, slot 0 leftmost.
  logic [NUM_DIGITS-1:0] show;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic seen;
  always_comb begin
    show = '0;
    seen = 1'b0;
    for (int s = 0; s < int'(NUM_DIGITS); s++) begin
      seen    = seen | (disp_q[int'(NUM_DIGITS) - 1 - s] != '0);
      show[s] = seen | (s == int'(NUM_DIGITS) - 1);
    end
  end
`else
  assign show = '1;
`endif

  logic [10:0] dx, dy, col;
  logic        in_box, in_glyph, drawn;
  bcd_t        dig;
  logic [9:0]  addr;
  logic        in1_q, in2_q;

  // Slot decode by a constant compare chain; the last matching lower bound wins.
  always_comb begin
    dx     = {1'b0, pixel_x} - 11'(ORIGIN_X);
    dy     = {1'b0, pixel_y} - 11'(ORIGIN_Y);
    in_box = ({1'b0, pixel_x} >= 11'(ORIGIN_X)) && ({1'b0, pixel_x} < 11'(ORIGIN_X + BoxW)) &&
             ({1'b0, pixel_y} >= 11'(ORIGIN_Y)) && ({1'b0, pixel_y} < 11'(ORIGIN_Y + GLYPH_H));
    col    = dx;
    dig    = '0;
    drawn  = 1'b1;
    for (int s = 0; s < int'(NUM_DIGITS); s++) begin
      if (dx >= 11'(s * int'(Pitch))) begin
        col   = dx - 11'(s * int'(Pitch));
        dig   = disp_q[int'(NUM_DIGITS) - 1 - s];
        drawn = show[s];
      end
    end
    in_glyph = in_box && (col < 11'(GLYPH_W)) && drawn;
    addr     = in_glyph ? 10'(dy * 11'(GLYPH_W) + col) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_digit <= '0;
      rom_addr  <= '0;
      in1_q     <= 1'b0;
      in2_q     <= 1'b0;
      pixel_on  <= 1'b0;
    end else begin
      rom_digit <= in_glyph ? dig : '0;
      rom_addr  <= addr;
      in1_q     <= in_glyph;
      in2_q     <= in1_q;
      pixel_on  <= in2_q & rom_q;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: arithmetic reference model plus directed checks.
module tb_score_display_ctrl;

  localparam int ND = 4, SW = 14, OX = 16, OY = 8, GW = 24, GH = 24, GAP = 4;
  localparam int PITCH = GW + GAP;
  localparam int CONV_BUSY = SW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] score = '0;
  logic          score_load = 1'b0;
  logic [9:0]    pixel_x = '0, pixel_y = '0;
  logic          rom_q = 1'b0;
  logic [3:0]    rom_digit;
  logic [9:0]    rom_addr;
  logic          pixel_on, busy;

  int  n_tests = 0, n_fail = 0;
  int  sw = 0;
  bit  chk_en = 1'b0;
  bit  rom_force = 1'b0;

  score_display_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score     (score),
    .score_load(score_load),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .rom_q     (rom_q),
    .rom_digit (rom_digit),
    .rom_addr  (rom_addr),
    .pixel_on  (pixel_on),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Glyph ROM stand-in: parity of digit/address, or all ones when forced.
  always @(posedge clk) rom_q <= rom_force | (^{rom_digit, rom_addr});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > p10(ND) - 1) ? p10(ND) - 1 : v;
  endfunction

  function automatic void geom(input int x, input int y, input int disp,
                               output bit ig, output int dig, output int addr);
    int dx, slot, col;
    bit drawn;
    ig = 0; dig = 0; addr = 0;
    if (x >= OX && x < OX + ND * PITCH - GAP && y >= OY && y < OY + GH) begin
      dx    = x - OX;
      slot  = dx / PITCH;
      col   = dx % PITCH;
      drawn = 1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      drawn = (slot == ND - 1) || (disp >= p10(ND - 1 - slot));
`endif
      if (col < GW && drawn) begin
        ig   = 1;
        dig  = (disp / p10(ND - 1 - slot)) % 10;
        addr = (y - OY) * GW + col;
      end
    end
  endfunction

  // Reference model state
  int         m_disp, m_busy_cnt, m_conv, m_pend_v;
  bit         m_pend;
  logic [3:0] e_digit;
  logic [9:0] e_addr;
  bit         e_in1, e_in2, e_rom, e_pix;
  bit         g_in;
  int         g_dig, g_addr;

  always_comb geom(int'(pixel_x), int'(pixel_y), m_disp, g_in, g_dig, g_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_disp <= 0; m_busy_cnt <= 0; m_conv <= 0; m_pend <= 0; m_pend_v <= 0;
      e_digit <= '0; e_addr <= '0; e_in1 <= 0; e_in2 <= 0; e_rom <= 0; e_pix <= 0;
    end else begin
      e_pix   <= e_in2 & e_rom;
      e_rom   <= rom_force | (^{e_digit, e_addr});
      e_in2   <= e_in1;
      e_in1   <= g_in;
      e_digit <= 4'(g_dig);
      e_addr  <= 10'(g_addr);
      if (m_busy_cnt == 0) begin
        if (score_load) begin
          m_conv <= sat(int'(score)); m_busy_cnt <= CONV_BUSY;
        end
      end else if (m_busy_cnt == 1) begin
        m_disp <= m_conv;
        if (score_load) begin
          m_conv <= sat(int'(score)); m_busy_cnt <= CONV_BUSY; m_pend <= 0;
        end else if (m_pend) begin
          m_conv <= m_pend_v; m_busy_cnt <= CONV_BUSY; m_pend <= 0;
        end else begin
          m_busy_cnt <= 0;
        end
      end else begin
        m_busy_cnt <= m_busy_cnt - 1;
        if (score_load) begin
          m_pend <= 1; m_pend_v <= sat(int'(score));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (m_busy_cnt != 0));
      check("rom_digit", rom_digit, e_digit);
      check("rom_addr", rom_addr, e_addr);
      check("pixel_on", pixel_on, e_pix);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sweep_step();
    pixel_x = 10'(10 + (sw % 125));
    pixel_y = 10'(6 + ((sw * 7) % 30));
    sw++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sweep_step();
    end
  endtask

  task automatic load(input int v);
    score = SW'(v);
    score_load = 1'b1;
    tick();
    score_load = 1'b0;
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      tick();
      sweep_step();
      k++;
    end
  endtask

  task automatic set_px(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  task automatic pix_after3(input int x, input int y, input string name, input logic exp);
    set_px(x, y);
    tick(); tick(); tick();
    check(name, pixel_on, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   k;
    logic rq;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_digit", rom_digit, 0);
    check("reset_addr", rom_addr, 0);
    check("reset_pixel", pixel_on, 0);

    // Score 0
    load(0);
    check("busy_after_load", busy, 1);
    wait_idle(k);
    check("conv_latency_0", k, CONV_BUSY);
    set_px(16, 8);
    tick();
    check("zero_digit", rom_digit, 0);
    check("zero_addr", rom_addr, 0);

    // 1234: slot 1, col 5, row 3
    load(1234);
    wait_idle(k);
    check("conv_latency_1234", k, CONV_BUSY);
    set_px(16 + 28 + 5, 8 + 3);
    tick();
    check("s1_digit", rom_digit, 2);
    check("s1_addr", rom_addr, 77);
    tick();
    rq = rom_q;
    tick();
    check("pix_eq_romq", pixel_on, rq);
    check("pix_lit_2_77", pixel_on, 1);
    run(130);

    // Saturation
    load(12345);
    wait_idle(k);
    set_px(16, 8);
    tick();
    check("sat_slot0", rom_digit, 9);
    set_px(100, 31);
    tick();
    check("sat_slot3", rom_digit, 9);
    check("sat_slot3_addr", rom_addr, 552);

    // Pending load on cycle 3 of CONVERT
    load(111);
    tick();
    tick();
    score = SW'(222);
    score_load = 1'b1;
    tick();
    score_load = 1'b0;
    wait_idle(k);
    check("pending_busy_span", k, 27);
    set_px(105, 10);
    tick();
    check("pend_slot3", rom_digit, 2);
    check("pend_slot3_addr", rom_addr, 53);

    // Gaps and outside area stay dark even with ROM all ones
    rom_force = 1'b1;
    pix_after3(16 + 24, 10, "gap_dark", 0);
    pix_after3(0, 0, "outside_dark", 0);
    pix_after3(49, 11, "forced_lit", 1);

    // Reset mid-conversion
    load(777);
    tick();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_lit", pixel_on, 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_digit", rom_digit, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_pixel", pixel_on, 0);
    tick();
    rst_n = 1'b1;
    set_px(105, 10);
    tick();
    check("cleared_digit", rom_digit, 0);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    load(7);
    wait_idle(k);
    pix_after3(21, 10, "blank_slot0", 0);
    pix_after3(105, 10, "lit_slot3", 1);
`else
    load(42);
    wait_idle(k);
    pix_after3(21, 10, "leading_zero_lit", 1);
    pix_after3(105, 10, "lit_slot3", 1);
`endif

    rom_force = 1'b0;
    run(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
